window_shift_reg: RTL and testbench
===================================

WINDOW_SHIFT_REG -- requirements
Module: window_shift_reg

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, bits per sample.
REQ-002 SHALL have parameter DEPTH, default 3, taps per lane, legal range 2..16.
REQ-003 SHALL have parameter LANES, default 1, independent parallel channels sharing control.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  shift enable; accepts one sample per lane.
- in_data  in  LANES*WIDTH  new samples; lane l occupies bits [l*WIDTH +: WIDTH].
- clear  in  1  synchronous flush.
- stride_m1  in  4  window stride minus one.
- taps  out  DEPTH*LANES*WIDTH  tap t of lane l at [(t*LANES+l)*WIDTH +: WIDTH]; tap 0 is newest.
- win_valid  out  1  one-cycle pulse marking a complete, stride-aligned window.
- fill_cnt  out  $clog2(DEPTH+1)  taps holding valid data, saturating at DEPTH.

Function
REQ-005 SHALL, on a clock edge with in_valid=1 and clear=0, load tap0 with in_data and tap t with the old tap t-1 (t=1..DEPTH-1), for every lane simultaneously.
REQ-006 SHALL hold all taps unchanged when in_valid=0.
REQ-007 SHALL present updated taps one cycle after the accepting edge; latency in_data to tap t is t+1 accepted shifts.
REQ-008 SHALL implement the FSM with these states and transitions:
- EMPTY: fill_cnt=0. A shift goes to FILL, or to STREAM if DEPTH would be reached.
- FILL: 0<fill_cnt<DEPTH. Goes to STREAM on the shift that makes fill_cnt=DEPTH.
- STREAM: taps full.
- clear from any state goes to EMPTY.
REQ-009 SHALL increment fill_cnt on each accepted shift and saturate it at DEPTH.
REQ-010 SHALL assert win_valid, registered and aligned with the updated taps, on the shift that enters STREAM.
REQ-011 In STREAM, SHALL count accepted shifts in a stride counter.
- The counter resets to 0 on each win_valid.
- win_valid asserts on the shift where counter = stride_m1 (the counter value before increment).
- stride_m1=0 gives a window on every shift.
REQ-012 SHALL sample stride_m1 at every comparison; a change takes effect from the next comparison; no buffering.
REQ-013 SHALL, on clear=1:
- zero all taps, fill_cnt and the stride counter;
- return to EMPTY;
- deassert win_valid on the next cycle.
REQ-014 SHALL give clear priority over in_valid in the same cycle; that sample is discarded.
REQ-015 SHALL deassert win_valid on any cycle without an accepted shift.

Reset
REQ-016 SHALL, while rst=1, asynchronously force:
- taps=0, fill_cnt=0, win_valid=0;
- stride counter=0;
- state=EMPTY.
REQ-017 SHALL treat a reset mid-operation identically to clear; no partial window survives.

Structure
REQ-018 SHALL place the FSM state enum (EMPTY, FILL, STREAM) and the stride-counter width constant in the shared convolver package.
REQ-019 SHALL instantiate one sub-module per lane, named lane_shift_chain (WIDTH, DEPTH), containing only the tap registers; the FSM, counters and win_valid are single-instance.

Verification
REQ-020 Fill, DEPTH=3, LANES=1, stride_m1=0: shift 10, 20, 30 ->
- win_valid first high after 30, with taps = {30, 20, 10};
- fill_cnt goes 1, 2, 3.
REQ-021 Stride, stride_m1=1, after fill: shift 40, 50, 60, 70 -> win_valid after 50 (taps {50,40,30}) and after 70 only.
REQ-022 Hold: in_valid low for 5 cycles mid-stream -> taps stable, win_valid=0 throughout, stride counter unchanged.
REQ-023 Clear collision: clear=1 with in_valid=1 and in_data=99 -> next cycle taps all 0, fill_cnt=0, win_valid=0, 99 absent.
REQ-024 Lanes and reset, LANES=2, DEPTH=4:
- lane0 samples 1..4 and lane1 samples 11..14 -> independent taps, one shared win_valid;
- async rst pulse between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/window_shift_reg_pkg.sv
// Shared types for the sliding-window shift register.
// Holds the fill/stream state encoding and stride counter width.
package window_shift_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } win_state_e;

   localparam int STRIDE_W = 4;

endpackage

// File: rtl/window_shift_reg_lane.sv
// One lane of tap registers; tap 0 holds the newest sample.
// Control is supplied by the single shared FSM in the top.
module lane_shift_chain #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   shift,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       din,
   output logic [DEPTH*WIDTH-1:0] taps
);

   logic [WIDTH-1:0] tap_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < DEPTH; t++) tap_q[t] <= '0;
      end else if (clear) begin
         for (int t = 0; t < DEPTH; t++) tap_q[t] <= '0;
      end else if (shift) begin
         tap_q[0] <= din;
         for (int t = 1; t < DEPTH; t++) tap_q[t] <= tap_q[t-1];
      end
   end

   for (genvar t = 0; t < DEPTH; t++) begin : g_out
      assign taps[t*WIDTH +: WIDTH] = tap_q[t];
   end

endmodule

// File: rtl/window_shift_reg.sv
// Multi-lane sliding-window shift register with fill tracking
// and a stride-aligned window strobe shared by all lanes.
module window_shift_reg
   import window_shift_reg_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3,
   parameter int LANES = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [LANES*WIDTH-1:0]       in_data,
   input  logic                         clear,
   input  logic [3:0]                   stride_m1,
   output logic [DEPTH*LANES*WIDTH-1:0] taps,
   output logic                         win_valid,
   output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);

   localparam int FW = $clog2(DEPTH+1);

   win_state_e          state_q, state_d;
   logic [FW-1:0]       fill_q, fill_d, fill_inc;
   logic [STRIDE_W-1:0] cnt_q, cnt_d;
   logic                win_q, win_d;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DEPTH*WIDTH-1:0] lane_taps;

      lane_shift_chain #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_chain (
         .clk   (clk),
         .rst   (rst),
         .shift (in_valid),
         .clear (clear),
         .din   (in_data[l*WIDTH +: WIDTH]),
         .taps  (lane_taps)
      );

      // Interleave lanes so that tap t of every lane sits together
      for (genvar t = 0; t < DEPTH; t++) begin : g_tap
         assign taps[(t*LANES+l)*WIDTH +: WIDTH] =
            lane_taps[t*WIDTH +: WIDTH];
      end
   end

   assign fill_inc = fill_q + FW'(1);

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      win_d   = 1'b0;
      if (clear) begin
         state_d = EMPTY;
         fill_d  = '0;
         cnt_d   = '0;
      end else if (in_valid) begin
         unique case (state_q)
            EMPTY, FILL: begin
               fill_d = fill_inc;
               if (fill_inc == FW'(DEPTH)) begin
                  state_d = STREAM;
                  win_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = FILL;
               end
            end
            STREAM: begin
               // stride_m1 is compared live; no shadow copy
               if (cnt_q == stride_m1) begin
                  win_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + STRIDE_W'(1);
               end
            end
            default: begin
               state_d = EMPTY;
               fill_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         fill_q  <= '0;
         cnt_q   <= '0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
      end
   end

   assign win_valid = win_q;
   assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_window_shift_reg.sv
// Directed bench: single-lane DEPTH=3 and two-lane DEPTH=4 instances.
module tb_window_shift_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        va, ca;
   logic [15:0] da;
   logic [3:0]  sa;
   logic [47:0] ta;
   logic        wa;
   logic [1:0]  fa;

   logic         vb, cb;
   logic [31:0]  db;
   logic [3:0]   sb;
   logic [127:0] tbt;
   logic         wb;
   logic [2:0]   fb;

   window_shift_reg #(
      .WIDTH (16),
      .DEPTH (3),
      .LANES (1)
   ) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (va),
      .in_data   (da),
      .clear     (ca),
      .stride_m1 (sa),
      .taps      (ta),
      .win_valid (wa),
      .fill_cnt  (fa)
   );

   window_shift_reg #(
      .WIDTH (16),
      .DEPTH (4),
      .LANES (2)
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vb),
      .in_data   (db),
      .clear     (cb),
      .stride_m1 (sb),
      .taps      (tbt),
      .win_valid (wb),
      .fill_cnt  (fb)
   );

   task automatic step_a(input logic v, input logic c,
                         input logic [15:0] d);
      @(negedge clk);
      va = v; ca = c; da = d;
      @(posedge clk);
      #1;
      va = 1'b0; ca = 1'b0;
   endtask

   task automatic step_b(input logic v,
                         input logic [15:0] d0,
                         input logic [15:0] d1);
      @(negedge clk);
      vb = v; db = {d1, d0};
      @(posedge clk);
      #1;
      vb = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (ta !== 48'd0) begin
         errors++;
         $display("FAIL reset_taps_a: got %h want 0", ta);
      end
      checks++;
      if (fa !== 2'd0 || wa !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl_a: fill=%0d win=%b want 0/0",
                  fa, wa);
      end
      checks++;
      if (tbt !== 128'd0 || fb !== 3'd0 || wb !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: taps=%h fill=%0d win=%b want 0",
                  tbt, fb, wb);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill;
      logic [15:0] vals [3];
      logic [47:0] exp;
      vals = '{16'd10, 16'd20, 16'd30};
      sa = 4'd0;
      for (int i = 0; i < 3; i++) begin
         step_a(1'b1, 1'b0, vals[i]);
         exp = '0;
         for (int j = 0; j <= i; j++)
            exp[(i-j)*16 +: 16] = vals[j];
         checks++;
         if (fa !== 2'(i+1)) begin
            errors++;
            $display("FAIL fill_cnt[%0d]: got %0d want %0d",
                     i, fa, i+1);
         end
         checks++;
         if (wa !== (i == 2)) begin
            errors++;
            $display("FAIL fill_win[%0d]: got %b want %b",
                     i, wa, (i == 2));
         end
         checks++;
         if (ta !== exp) begin
            errors++;
            $display("FAIL fill_taps[%0d]: got %h want %h",
                     i, ta, exp);
         end
      end
   endtask

   task automatic test_stride;
      logic [15:0] vals [4];
      vals = '{16'd40, 16'd50, 16'd60, 16'd70};
      sa = 4'd1;
      for (int i = 0; i < 4; i++) begin
         step_a(1'b1, 1'b0, vals[i]);
         checks++;
         if (wa !== (i == 1 || i == 3)) begin
            errors++;
            $display("FAIL stride_win[%0d]: got %b want %b",
                     i, wa, (i == 1 || i == 3));
         end
         if (i == 1) begin
            checks++;
            if (ta !== {16'd30, 16'd40, 16'd50}) begin
               errors++;
               $display("FAIL stride_taps: got %h want %h",
                        ta, {16'd30, 16'd40, 16'd50});
            end
         end
      end
      checks++;
      if (fa !== 2'd3) begin
         errors++;
         $display("FAIL fill_sat: got %0d want 3", fa);
      end
   endtask

   task automatic test_hold;
      step_a(1'b1, 1'b0, 16'd80);
      checks++;
      if (wa !== 1'b0) begin
         errors++;
         $display("FAIL hold_pre_win: got %b want 0", wa);
      end
      for (int i = 0; i < 5; i++) begin
         step_a(1'b0, 1'b0, 16'hdead);
         checks++;
         if (ta !== {16'd60, 16'd70, 16'd80} || wa !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: taps=%h win=%b want %h/0",
                     i, ta, wa, {16'd60, 16'd70, 16'd80});
         end
      end
      step_a(1'b1, 1'b0, 16'd90);
      checks++;
      if (wa !== 1'b1) begin
         errors++;
         $display("FAIL hold_cnt_kept: win=%b want 1", wa);
      end
      step_a(1'b0, 1'b0, 16'd0);
      checks++;
      if (wa !== 1'b0) begin
         errors++;
         $display("FAIL win_idle_drop: got %b want 0", wa);
      end
   endtask

   task automatic test_clear;
      step_a(1'b1, 1'b1, 16'd99);
      checks++;
      if (ta !== 48'd0 || fa !== 2'd0 || wa !== 1'b0) begin
         errors++;
         $display("FAIL clear: taps=%h fill=%0d win=%b want 0",
                  ta, fa, wa);
      end
      sa = 4'd0;
      step_a(1'b1, 1'b0, 16'd5);
      checks++;
      if (ta !== {16'd0, 16'd0, 16'd5} || fa !== 2'd1 ||
          wa !== 1'b0) begin
         errors++;
         $display("FAIL clear_refill: taps=%h fill=%0d win=%b",
                  ta, fa, wa);
      end
   endtask

   task automatic test_lanes;
      logic [127:0] exp;
      sb = 4'd0;
      for (int i = 0; i < 4; i++) begin
         step_b(1'b1, 16'(i+1), 16'(i+11));
         checks++;
         if (fb !== 3'(i+1) || wb !== (i == 3)) begin
            errors++;
            $display("FAIL lanes_ctl[%0d]: fill=%0d win=%b", i, fb, wb);
         end
      end
      exp = {16'd11, 16'd1, 16'd12, 16'd2,
             16'd13, 16'd3, 16'd14, 16'd4};
      checks++;
      if (tbt !== exp) begin
         errors++;
         $display("FAIL lanes_taps: got %h want %h", tbt, exp);
      end
   endtask

   task automatic test_async_reset;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (tbt !== 128'd0 || fb !== 3'd0 || wb !== 1'b0) begin
         errors++;
         $display("FAIL async_rst_b: taps=%h fill=%0d win=%b",
                  tbt, fb, wb);
      end
      checks++;
      if (ta !== 48'd0 || fa !== 2'd0) begin
         errors++;
         $display("FAIL async_rst_a: taps=%h fill=%0d", ta, fa);
      end
      @(negedge clk);
      rst = 1'b0;
      step_b(1'b1, 16'd7, 16'd17);
      checks++;
      if (fb !== 3'd1 || wb !== 1'b0 ||
          tbt !== {96'd0, 16'd17, 16'd7}) begin
         errors++;
         $display("FAIL post_rst: taps=%h fill=%0d win=%b",
                  tbt, fb, wb);
      end
   endtask

   initial begin
      rst = 1'b1;
      va = 1'b0; ca = 1'b0; da = '0; sa = '0;
      vb = 1'b0; cb = 1'b0; db = '0; sb = '0;
      test_reset;
      test_fill;
      test_stride;
      test_hold;
      test_clear;
      test_lanes;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
